// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: fetch FSM encoding, instruction width,
// register-field positions (also used by the decoder and hazard unit)
// and the default reset PC.
package mips_pkg;

  localparam int unsigned INSTR_W   = 32;
  localparam int unsigned REG_IDX_W = 5;

  localparam int unsigned RS_MSB = 25;
  localparam int unsigned RS_LSB = 21;
  localparam int unsigned RT_MSB = 20;
  localparam int unsigned RT_LSB = 16;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register with load/hold/flush control.
//   load       : capture instr_d/pc_plus4_d, mark valid
//   flush      : mark bubble (payload kept, qualified by valid)
//   neither    : hold
//   rs_c/rt_c  : register fields decoded combinationally from the stored word
module ifid_reg
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 flush,
  input  logic [INSTR_W-1:0]   instr_d,
  input  logic [ADDR_W-1:0]    pc_plus4_d,
  output logic [INSTR_W-1:0]   instr,
  output logic [ADDR_W-1:0]    pc_plus4,
  output logic                 valid,
  output logic [REG_IDX_W-1:0] rs_c,
  output logic [REG_IDX_W-1:0] rt_c
);

  // Load has priority over flush; hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr    <= '0;
      pc_plus4 <= '0;
      valid    <= 1'b0;
    end else if (load) begin
      instr    <= instr_d;
      pc_plus4 <= pc_plus4_d;
      valid    <= 1'b1;
    end else if (flush) begin
      valid    <= 1'b0;
    end
  end

  assign rs_c = instr[RS_MSB:RS_LSB];
  assign rt_c = instr[RT_MSB:RT_LSB];

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, imem req/ready handshake, stall hold buffer
// and branch redirect, feeding the IF/ID register.
// Ports: clk, rst_n (async active-low); stall, branch_taken, branch_target
// from hazard unit / ID; imem_req, imem_addr, imem_ready, imem_rdata to
// instruction memory; IFID_* pipeline register outputs (rs/rt are
// combinational decodes of the registered instruction).
// Build option BRANCH_DELAY_SLOT_EN: keep the branch successor (delay slot)
// and retarget the PC once it enters IF/ID; otherwise flush it.
module fetch_stage
  import mips_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  input  logic                 branch_taken,
  input  logic [ADDR_W-1:0]    branch_target,
  output logic                 imem_req,
  output logic [ADDR_W-1:0]    imem_addr,
  input  logic                 imem_ready,
  input  logic [INSTR_W-1:0]   imem_rdata,
  output logic [INSTR_W-1:0]   IFID_instr,
  output logic [ADDR_W-1:0]    IFID_pc_plus4,
  output logic                 IFID_valid,
  output logic [REG_IDX_W-1:0] IFID_register_rs,
  output logic [REG_IDX_W-1:0] IFID_register_rt
);

  fetch_state_e         state, state_next;
  logic [ADDR_W-1:0]    pc, pc_next, pc_plus4, target;
  logic [ADDR_W-1:0]    addr_q, addr_next;
  logic [INSTR_W-1:0]   hold_buf, hold_buf_next, ifid_instr_d;
  logic                 req_q;
  logic                 redirect, ifid_load, ifid_flush;
  logic                 unused_target_lsbs;
`ifdef BRANCH_DELAY_SLOT_EN
  logic [ADDR_W-1:0]    redirect_pending, redirect_pending_next;
  logic                 pending_valid, pending_valid_next;
  logic                 accept;
`else
  logic                 discard, discard_next;
`endif

  assign pc_plus4           = pc + ADDR_W'(4);
  assign target             = {branch_target[ADDR_W-1:2], 2'b00};
  assign unused_target_lsbs = ^branch_target[1:0];
  // Stall outranks a same-cycle branch.
  assign redirect           = branch_taken & ~stall;

  // Next-state, PC and IF/ID control.
  always_comb begin
    state_next    = state;
    pc_next       = pc;
    addr_next     = addr_q;
    hold_buf_next = hold_buf;
    ifid_load     = 1'b0;
    ifid_flush    = 1'b0;
    ifid_instr_d  = imem_rdata;
`ifdef BRANCH_DELAY_SLOT_EN
    redirect_pending_next = redirect_pending;
    pending_valid_next    = pending_valid;
    accept                = 1'b0;
`else
    discard_next  = discard;
`endif

    unique case (state)
      S_BOOT: state_next = S_FETCH;

      S_FETCH: begin
`ifdef BRANCH_DELAY_SLOT_EN
        if (imem_ready && !stall) begin
          ifid_load = 1'b1;
          accept    = 1'b1;
        end else if (imem_ready) begin
          hold_buf_next = imem_rdata;
          state_next    = S_HOLD;
        end else if (!stall) begin
          ifid_flush = 1'b1;
        end
`else
        if (discard) begin
          // Wrong-path request still open: swallow its data when it lands.
          if (imem_ready) discard_next = 1'b0;
          if (!stall)     ifid_flush   = 1'b1;
          if (redirect)   pc_next      = target;
        end else if (redirect) begin
          ifid_flush = 1'b1;
          pc_next    = target;
          if (!imem_ready) discard_next = 1'b1;
        end else if (imem_ready && !stall) begin
          ifid_load = 1'b1;
          pc_next   = pc_plus4;
        end else if (imem_ready) begin
          hold_buf_next = imem_rdata;
          state_next    = S_HOLD;
        end else if (!stall) begin
          ifid_flush = 1'b1;
        end
`endif
      end

      S_HOLD: begin
        ifid_instr_d = hold_buf;
        if (!stall) begin
          state_next = S_FETCH;
`ifdef BRANCH_DELAY_SLOT_EN
          ifid_load = 1'b1;
          accept    = 1'b1;
`else
          if (redirect) begin
            ifid_flush = 1'b1;
            pc_next    = target;
          end else begin
            ifid_load = 1'b1;
            pc_next   = pc_plus4;
          end
`endif
        end
      end

      default: state_next = S_BOOT;
    endcase

`ifdef BRANCH_DELAY_SLOT_EN
    // The delay-slot word entering IF/ID is the point where the PC jumps.
    if (accept) begin
      pending_valid_next = 1'b0;
      if (redirect)           pc_next = target;
      else if (pending_valid) pc_next = redirect_pending;
      else                    pc_next = pc_plus4;
    end else if (redirect) begin
      pending_valid_next    = 1'b1;
      redirect_pending_next = target;
    end
`endif

    // An open request keeps its address even if the PC moves underneath it.
    if (!(state == S_FETCH && !imem_ready)) addr_next = pc_next;
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_BOOT;
      pc       <= {RESET_PC[ADDR_W-1:2], 2'b00};
      addr_q   <= {RESET_PC[ADDR_W-1:2], 2'b00};
      hold_buf <= '0;
      req_q    <= 1'b0;
`ifdef BRANCH_DELAY_SLOT_EN
      redirect_pending <= '0;
      pending_valid    <= 1'b0;
`else
      discard  <= 1'b0;
`endif
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      addr_q   <= addr_next;
      hold_buf <= hold_buf_next;
      req_q    <= (state_next == S_FETCH);
`ifdef BRANCH_DELAY_SLOT_EN
      redirect_pending <= redirect_pending_next;
      pending_valid    <= pending_valid_next;
`else
      discard  <= discard_next;
`endif
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;

  ifid_reg #(
    .ADDR_W (ADDR_W)
  ) u_ifid_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (ifid_load),
    .flush      (ifid_flush),
    .instr_d    (ifid_instr_d),
    .pc_plus4_d (pc_plus4),
    .instr      (IFID_instr),
    .pc_plus4   (IFID_pc_plus4),
    .valid      (IFID_valid),
    .rs_c       (IFID_register_rs),
    .rt_c       (IFID_register_rt)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed stall/branch/reset vectors,
// a transaction-level fetch model checked every cycle, and literal spot checks.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] IFID_instr;
  logic [31:0] IFID_pc_plus4;
  logic        IFID_valid;
  logic [4:0]  IFID_register_rs;
  logic [4:0]  IFID_register_rt;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  fetch_stage dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .stall            (stall),
    .branch_taken     (branch_taken),
    .branch_target    (branch_target),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_ready       (imem_ready),
    .imem_rdata       (imem_rdata),
    .IFID_instr       (IFID_instr),
    .IFID_pc_plus4    (IFID_pc_plus4),
    .IFID_valid       (IFID_valid),
    .IFID_register_rs (IFID_register_rs),
    .IFID_register_rt (IFID_register_rt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory content: address 0 holds lw $2,4($1); other words vary with address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h8C22_0004 ^ {a[15:0], a[15:0]};
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model of the fetch unit.
  bit          m_boot, m_req_on, m_parked, m_drop, m_pend;
  logic [31:0] m_pc, m_req_addr, m_parked_word, m_pend_pc;
  logic [31:0] e_instr, e_pc4;
  bit          e_valid;

  task automatic model_reset();
    m_boot = 1'b1; m_req_on = 1'b0; m_parked = 1'b0; m_drop = 1'b0; m_pend = 1'b0;
    m_pc = 32'h0; m_req_addr = 32'h0; m_parked_word = 32'h0; m_pend_pc = 32'h0;
    e_instr = 32'h0; e_pc4 = 32'h0; e_valid = 1'b0;
  endtask

  task automatic deliver(input logic [31:0] w, input bit redir, input logic [31:0] tgt);
    e_instr = w;
    e_pc4   = m_pc + 32'd4;
    e_valid = 1'b1;
`ifdef BRANCH_DELAY_SLOT_EN
    if (redir)       m_pc = tgt;
    else if (m_pend) m_pc = m_pend_pc;
    else             m_pc = m_pc + 32'd4;
    m_pend = 1'b0;
`else
    if (redir) m_pc = tgt; // never reached in flush mode
    else       m_pc = m_pc + 32'd4;
`endif
  endtask

  task automatic model_step(input bit s, input bit b, input logic [31:0] t, input bit r);
    bit          redir, fetching;
    logic [31:0] tgt, w;
    redir    = b && !s;
    tgt      = {t[31:2], 2'b00};
    w        = mem_word(m_req_addr);
    fetching = !m_boot && !m_parked;
    if (m_boot) begin
      m_boot   = 1'b0;
      m_req_on = 1'b1;
    end else if (m_parked) begin
      if (!s) begin
        m_parked = 1'b0;
        m_req_on = 1'b1;
`ifdef BRANCH_DELAY_SLOT_EN
        deliver(m_parked_word, redir, tgt);
`else
        if (redir) begin e_valid = 1'b0; m_pc = tgt; end
        else deliver(m_parked_word, 1'b0, tgt);
`endif
      end
    end else begin
`ifdef BRANCH_DELAY_SLOT_EN
      if (r && !s) deliver(w, redir, tgt);
      else begin
        if (r) begin m_parked = 1'b1; m_parked_word = w; m_req_on = 1'b0; end
        else if (!s) e_valid = 1'b0;
        if (redir) begin m_pend = 1'b1; m_pend_pc = tgt; end
      end
`else
      if (m_drop) begin
        if (r)     m_drop  = 1'b0;
        if (!s)    e_valid = 1'b0;
        if (redir) m_pc    = tgt;
      end else if (redir) begin
        e_valid = 1'b0;
        m_pc    = tgt;
        if (!r) m_drop = 1'b1;
      end else if (r && !s) deliver(w, 1'b0, tgt);
      else if (r) begin m_parked = 1'b1; m_parked_word = w; m_req_on = 1'b0; end
      else if (!s) e_valid = 1'b0;
`endif
    end
    if (!(fetching && !r)) m_req_addr = m_pc;
  endtask

  // Per-cycle comparison of DUT outputs against the model.
  always @(posedge clk) begin
    if (chk_en) begin
      #1;
      check("imem_req", 32'(imem_req), 32'(m_req_on));
      check("imem_addr", imem_addr, m_req_addr);
      check("IFID_valid", 32'(IFID_valid), 32'(e_valid));
      if (e_valid) begin
        check("IFID_instr", IFID_instr, e_instr);
        check("IFID_pc_plus4", IFID_pc_plus4, e_pc4);
        check("IFID_rs", 32'(IFID_register_rs), 32'(e_instr[25:21]));
        check("IFID_rt", 32'(IFID_register_rt), 32'(e_instr[20:16]));
      end
    end
  end

  // Called at a falling edge; returns at the following falling edge.
  task automatic cycle(input bit s, input bit b, input logic [31:0] t, input bit r);
    stall = s; branch_taken = b; branch_target = t; imem_ready = r;
    model_step(s, b, t, r);
    @(posedge clk);
    #1;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0; imem_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_req", 32'(imem_req), 32'h0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", 32'(IFID_valid), 32'h0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    cycle(0, 0, 32'h0, 1);                          // boot
    check("boot_req", 32'(imem_req), 32'h1);
    check("boot_addr", imem_addr, 32'h0);
    cycle(0, 0, 32'h0, 1);
    check("first_instr", IFID_instr, 32'h8C22_0004);
    check("first_rs", 32'(IFID_register_rs), 32'd1);
    check("first_rt", 32'(IFID_register_rt), 32'd2);
    check("first_pc4", IFID_pc_plus4, 32'h4);
    check("first_valid", 32'(IFID_valid), 32'h1);
    check("addr_4", imem_addr, 32'h4);
    cycle(0, 0, 32'h0, 1);
    check("addr_8", imem_addr, 32'h8);

    cycle(1, 0, 32'h0, 1);                          // stall with data at 0x8
    check("hold_req", 32'(imem_req), 32'h0);
    check("hold_pc4_a", IFID_pc_plus4, 32'h8);
    cycle(1, 0, 32'h0, 0);
    check("hold_pc4_b", IFID_pc_plus4, 32'h8);
    cycle(0, 0, 32'h0, 0);                          // release
    check("release_instr", IFID_instr, 32'h8C2A_000C);
    check("release_pc4", IFID_pc_plus4, 32'hC);
    check("release_addr", imem_addr, 32'hC);
    cycle(0, 0, 32'h0, 1);

`ifndef BRANCH_DELAY_SLOT_EN
    cycle(0, 1, 32'h100, 0);                        // branch over outstanding 0x10
    check("redir_addr_hold", imem_addr, 32'h10);
    check("redir_flush", 32'(IFID_valid), 32'h0);
    cycle(0, 0, 32'h0, 0);
    cycle(0, 0, 32'h0, 1);
    check("drop_valid", 32'(IFID_valid), 32'h0);
    check("target_addr", imem_addr, 32'h100);
    cycle(0, 0, 32'h0, 1);
    check("target_instr", IFID_instr, 32'h8D22_0104);
    check("target_pc4", IFID_pc_plus4, 32'h104);
    cycle(1, 1, 32'h300, 0);                        // stall beats branch
    cycle(0, 0, 32'h0, 1);
    check("ignored_branch_pc4", IFID_pc_plus4, 32'h108);
    check("ignored_branch_addr", imem_addr, 32'h108);
    cycle(1, 0, 32'h0, 1);                          // park 0x108
    cycle(0, 1, 32'h203, 0);                        // branch drops buffer
    check("hold_redir_valid", 32'(IFID_valid), 32'h0);
    check("hold_redir_addr", imem_addr, 32'h200);
    cycle(0, 1, 32'hFFFF_FFFE, 1);                  // branch with data returning
    check("same_cycle_drop", 32'(IFID_valid), 32'h0);
    check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    cycle(0, 0, 32'h0, 1);
    check("wrap_pc4", IFID_pc_plus4, 32'h0);
    check("wrap_next_addr", imem_addr, 32'h0);
    cycle(0, 1, 32'h20, 1);
    cycle(0, 0, 32'h0, 0);                          // request at 0x20 open
    check("pre_reset_addr", imem_addr, 32'h20);
`else
    for (int i = 0; i < 6; i++) cycle(0, (i == 2), 32'h200, (i % 2 == 0));
    cycle(0, 1, 32'h20, 0);
    cycle(0, 0, 32'h0, 1);
    cycle(0, 0, 32'h0, 0);
`endif

    chk_en = 1'b0;                                  // reset mid-request
    #2 rst_n = 1'b0;
    #1;
    check("midrst_req", 32'(imem_req), 32'h0);
    check("midrst_addr", imem_addr, 32'h0);
    check("midrst_valid", 32'(IFID_valid), 32'h0);
    model_reset();
    stall = 1'b0; branch_taken = 1'b0; imem_ready = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    cycle(0, 0, 32'h0, 1);
    check("reboot_addr", imem_addr, 32'h0);
    check("reboot_req", 32'(imem_req), 32'h1);

`ifdef BRANCH_DELAY_SLOT_EN
    cycle(0, 1, 32'h40, 1);
    cycle(0, 0, 32'h0, 1);
    check("bds_branch_pc4", IFID_pc_plus4, 32'h44);
    cycle(0, 1, 32'h200, 0);                        // branch at 0x40, slot 0x44 open
    check("bds_slot_addr", imem_addr, 32'h44);
    cycle(0, 0, 32'h0, 1);
    check("bds_slot_instr", IFID_instr, 32'h8C66_0040);
    check("bds_slot_valid", 32'(IFID_valid), 32'h1);
    check("bds_target_addr", imem_addr, 32'h200);
`endif

    for (int i = 0; i < 4; i++) cycle(0, 0, 32'h0, 1);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register of the 5-stage MIPS core, directly upstream of the load-use hazard unit.
- Owns the PC and issues requests to instruction memory over a req/ready handshake. Holds the IF/ID register and exposes its rs/rt fields to the hazard unit.
- Consumes the hazard unit's stall (freeze PC and IF/ID) and ID-stage branch redirects (retarget PC, flush the wrong-path instruction).

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset (word aligned).
- ADDR_W, 32, PC and memory address width.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  from hazard unit; 1 = hold PC and IF/ID this cycle.
- branch_taken  in  1  one-cycle pulse from ID; redirect fetch.
- branch_target  in  ADDR_W  redirect address, valid with branch_taken.
- imem_req  out  1  fetch request.
- imem_addr  out  ADDR_W  fetch address; stable while imem_req=1 and imem_ready=0.
- imem_ready  in  1  1 = imem_rdata valid this cycle; completes the request.
- imem_rdata  in  32  instruction word.
- IFID_instr  out  32  registered instruction.
- IFID_pc_plus4  out  ADDR_W  registered PC+4 of IFID_instr.
- IFID_valid  out  1  1 = IF/ID holds a real instruction; 0 = bubble.
- IFID_register_rs  out  5  IFID_instr[25:21], combinational from the register.
- IFID_register_rt  out  5  IFID_instr[20:16], combinational from the register.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - pc=RESET_PC; IFID_instr, IFID_pc_plus4 and IFID_valid = 0; imem_req=0.
  - state=S_BOOT; discard=0; redirect_pending=0.
- S_BOOT: imem_req=0; unconditionally -> S_FETCH next cycle.
- S_FETCH: imem_req=1, imem_addr=pc.
  - imem_ready=0, stall=0: IFID_valid<=0 (bubble); stay.
  - imem_ready=1, stall=0: IF/ID <= {rdata, pc+4, valid=1}; pc<=pc+4; stay. Back-to-back: 1 instruction/cycle with zero-wait memory.
  - imem_ready=1, stall=1: rdata captured in the 32-bit hold buffer; IF/ID unchanged; pc unchanged -> S_HOLD.
  - imem_ready=0, stall=1: IF/ID unchanged.
- S_HOLD: imem_req=0. While stall=1, IF/ID and the buffer are unchanged. On stall=0: IF/ID <= {buffer, pc+4, 1}; pc<=pc+4 -> S_FETCH.
- Redirect:
  - branch_taken is sampled only when stall=0. If stall=1 and branch_taken=1 in the same cycle, stall wins and branch_taken is ignored.
  - At the sampling edge: IFID_valid<=0 (the sequential successor is wrong-path) and pc<=branch_target.
  - S_HOLD: the buffer is dropped -> S_FETCH.
  - S_FETCH with the request outstanding (imem_ready=0): the request is not withdrawn. discard<=1 and pc<=branch_target. When ready arrives, the data is dropped, discard<=0, IFID_valid stays 0, and the next cycle fetches the target.
  - S_FETCH with imem_ready=1 in the same cycle: the returning word is dropped.
- Width rules:
  - pc+4 wraps modulo 2^ADDR_W with no flag.
  - branch_target[1:0] is ignored; pc[1:0] is forced to 0.
- stall and imem_ready are independent; all state changes occur only on the rising edge of clk.

Optional Feature:
- Macro BRANCH_DELAY_SLOT_EN.
- Defined (MIPS delay-slot semantics):
  - On branch_taken, the sequential successor (branch PC+4) is not discarded. It is delivered to IF/ID normally, from the in-flight request, the hold buffer, or a new fetch.
  - branch_target is latched in redirect_pending. The PC is loaded from redirect_pending when the successor is accepted into IF/ID.
  - A second branch_taken before that acceptance overwrites redirect_pending.
- Undefined: the flush behaviour above; no redirect_pending register is synthesized.

Decomposition:
- Shared package mips_pkg holds:
  - fetch state encoding (S_BOOT, S_FETCH, S_HOLD);
  - INSTR_W=32;
  - the field-position constants RS_MSB/RS_LSB and RT_MSB/RT_LSB, also used by the decoder and hazard unit;
  - the default RESET_PC.
- One natural sub-module, ifid_reg: the IF/ID register with load/hold/flush controls and the combinational rs/rt extraction. fetch_stage contains the PC, FSM and hold buffer.

Test Plan:
- Reset then zero-wait memory returning rdata=0x8C220004 on pc 0x0 -> imem_addr 0x0, 0x4, 0x8 on consecutive cycles; IFID_instr=0x8C220004 with IFID_register_rs=1, rt=2, IFID_pc_plus4=0x4, valid=1.
- stall=1 for 2 cycles while imem_ready=1 at pc 0x8 -> IF/ID frozen for both cycles; state S_HOLD; after release, IF/ID gets the buffered word with pc_plus4=0xC and the next imem_addr=0xC.
- branch_taken with target 0x100 while the 0x10 request is outstanding 3 cycles -> imem_addr stays 0x10 until ready; that data is dropped with IFID_valid=0; next imem_addr=0x100.
- stall=1 and branch_taken=1 in the same cycle -> branch ignored; pc unchanged.
- Assert rst_n=0 mid-request (pc=0x20) -> outputs immediately at reset values; after release, first imem_addr=RESET_PC.
- BRANCH_DELAY_SLOT_EN: branch at 0x40 to target 0x200 -> instruction 0x44 delivered with valid=1, then imem_addr=0x200.
